// File: rtl/phase_checker.sv
// Four-phase clock monitor: checks exactly-one-low, in-order rotation of the
// active-low phases, and reports lock, current phase, frame and fault counters.
//
// state   | meaning
// HUNT    | no usable history, waiting for any valid sample
// LOCKING | counting consecutive in-order samples towards LOCK_COUNT
// LOCKED  | rotation verified; any bad sample is a loss of lock
module phase_checker #(
  parameter int LOCK_COUNT = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk12,
  input  logic             reset_n,
  input  logic             phi1,
  input  logic             phi2,
  input  logic             phi3,
  input  logic             phi4,
  input  logic             clr_err,
  output logic             locked,
  output logic [1:0]       phase_idx,
  output logic             frame,
  output logic [CNT_W-1:0] frame_count,
  output logic             err_pulse,
  output logic             err_sticky,
  output logic [CNT_W-1:0] err_count
);

  typedef enum logic [1:0] {HUNT, LOCKING, LOCKED} state_t;

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [3:0] LOCK_N = 4'(LOCK_COUNT);

  state_t           r_state;
  logic [3:0]       r_good_cnt;
  logic [1:0]       r_prev_idx;
  logic             r_locked;
  logic [1:0]       r_phase_idx;
  logic             r_frame;
  logic [CNT_W-1:0] r_frame_count;
  logic             r_err_pulse;
  logic             r_err_sticky;
  logic [CNT_W-1:0] r_err_count;

  logic [3:0]       w_low;
  logic             w_valid;
  logic [1:0]       w_idx;
  logic [1:0]       w_next_idx;
  logic             w_in_order;
  logic             w_fault;
  logic [CNT_W-1:0] w_err_inc;

  assign w_low = ~{phi4, phi3, phi2, phi1};
  assign w_valid = $onehot(w_low);

  always_comb begin
    w_idx = 2'd0;
    case (w_low)
      4'b0010: w_idx = 2'd1;
      4'b0100: w_idx = 2'd2;
      4'b1000: w_idx = 2'd3;
      default: w_idx = 2'd0;
    endcase
  end

  assign w_next_idx = r_prev_idx + 2'd1;
  assign w_in_order = (w_idx == w_next_idx);
  assign w_fault    = (r_state == LOCKED) && !(w_valid && w_in_order);
  assign w_err_inc  = (&r_err_count) ? r_err_count : r_err_count + ONE;

  always_ff @(posedge clk12 or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= HUNT;
      r_good_cnt    <= 4'd0;
      r_prev_idx    <= 2'd0;
      r_locked      <= 1'b0;
      r_phase_idx   <= 2'd0;
      r_frame       <= 1'b0;
      r_frame_count <= '0;
      r_err_pulse   <= 1'b0;
      r_err_sticky  <= 1'b0;
      r_err_count   <= '0;
    end else begin
      r_frame     <= 1'b0;
      r_err_pulse <= 1'b0;

      if (w_valid) r_phase_idx <= w_idx;

      // A fault on the same edge as clr_err wins over the clear
      if (w_fault) begin
        r_err_sticky <= 1'b1;
        r_err_count  <= clr_err ? ONE : w_err_inc;
      end else if (clr_err) begin
        r_err_sticky <= 1'b0;
        r_err_count  <= '0;
      end

      case (r_state)
        HUNT: begin
          if (w_valid) begin
            r_prev_idx <= w_idx;
            r_good_cnt <= 4'd1;
            r_state    <= LOCKING;
          end
        end
        LOCKING: begin
          if (!w_valid) begin
            r_good_cnt <= 4'd0;
            r_state    <= HUNT;
          end else if (w_in_order) begin
            r_prev_idx <= w_idx;
            r_good_cnt <= r_good_cnt + 4'd1;
            if (r_good_cnt + 4'd1 == LOCK_N) begin
              r_state  <= LOCKED;
              r_locked <= 1'b1;
            end
          end else begin
            r_prev_idx <= w_idx;
            r_good_cnt <= 4'd1;
          end
        end
        LOCKED: begin
          if (!w_fault) begin
            r_prev_idx <= w_idx;
            if (w_idx == 2'd0) begin
              r_frame       <= 1'b1;
              r_frame_count <= r_frame_count + ONE;
            end
          end else begin
            r_locked    <= 1'b0;
            r_err_pulse <= 1'b1;
            r_good_cnt  <= 4'd0;
            r_state     <= HUNT;
          end
        end
        default: begin
          r_good_cnt <= 4'd0;
          r_state    <= HUNT;
        end
      endcase
    end
  end

  assign locked      = r_locked;
  assign phase_idx   = r_phase_idx;
  assign frame       = r_frame;
  assign frame_count = r_frame_count;
  assign err_pulse   = r_err_pulse;
  assign err_sticky  = r_err_sticky;
  assign err_count   = r_err_count;

endmodule

// File: tb/tb_phase_checker.sv
// Directed bench for phase_checker: a 16-bit counter instance and a 2-bit
// counter instance share the same phase stimulus.
module tb_phase_checker;

  logic clk12 = 1'b0;
  logic reset_n = 1'b0;
  logic phi1 = 1'b1, phi2 = 1'b1, phi3 = 1'b1, phi4 = 1'b1;
  logic clr_err = 1'b0;

  logic        locked, frame, err_pulse, err_sticky;
  logic [1:0]  phase_idx;
  logic [15:0] frame_count, err_count;

  logic        s_locked, s_frame, s_err_pulse, s_err_sticky;
  logic [1:0]  s_phase_idx;
  logic [1:0]  s_frame_count, s_err_count;

  int n_cmp = 0;
  int n_err = 0;

  phase_checker dut (
    .clk12(clk12), .reset_n(reset_n),
    .phi1(phi1), .phi2(phi2), .phi3(phi3), .phi4(phi4), .clr_err(clr_err),
    .locked(locked), .phase_idx(phase_idx), .frame(frame),
    .frame_count(frame_count), .err_pulse(err_pulse),
    .err_sticky(err_sticky), .err_count(err_count)
  );

  phase_checker #(.CNT_W(2)) dut_s (
    .clk12(clk12), .reset_n(reset_n),
    .phi1(phi1), .phi2(phi2), .phi3(phi3), .phi4(phi4), .clr_err(clr_err),
    .locked(s_locked), .phase_idx(s_phase_idx), .frame(s_frame),
    .frame_count(s_frame_count), .err_pulse(s_err_pulse),
    .err_sticky(s_err_sticky), .err_count(s_err_count)
  );

  always #5 clk12 = ~clk12;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] pat(input int i);
    logic [3:0] p;
    p = 4'b1111;
    p[i % 4] = 1'b0;
    return p;
  endfunction

  // Drive {phi4,phi3,phi2,phi1} before the edge, return just after it
  task automatic step(input logic [3:0] ph, input logic clr);
    @(negedge clk12);
    {phi4, phi3, phi2, phi1} = ph;
    clr_err = clr;
    @(posedge clk12);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_locked"}, {31'd0, locked}, 0);
    chk({tag, "_idx"}, {30'd0, phase_idx}, 0);
    chk({tag, "_frame"}, {31'd0, frame}, 0);
    chk({tag, "_fcnt"}, {16'd0, frame_count}, 0);
    chk({tag, "_epulse"}, {31'd0, err_pulse}, 0);
    chk({tag, "_sticky"}, {31'd0, err_sticky}, 0);
    chk({tag, "_ecnt"}, {16'd0, err_count}, 0);
    chk({tag, "_s_locked"}, {31'd0, s_locked}, 0);
    chk({tag, "_s_ecnt"}, {30'd0, s_err_count}, 0);
  endtask

  task automatic lock_then_fault(input int k, input logic clr,
                                 input int exp_main, input int exp_small);
    for (int i = 0; i < 4; i++) step(pat(i), 1'b0);
    chk($sformatf("sat_locked_%0d", k), {31'd0, locked}, 1);
    step(4'b0110, clr);
    chk($sformatf("sat_epulse_%0d", k), {31'd0, err_pulse}, 1);
    chk($sformatf("sat_ecnt_%0d", k), {16'd0, err_count}, exp_main);
    chk($sformatf("sat_s_ecnt_%0d", k), {30'd0, s_err_count}, exp_small);
    chk($sformatf("sat_sticky_%0d", k), {31'd0, err_sticky}, 1);
  endtask

  initial begin
    // Lock-up
    repeat (3) @(posedge clk12);
    #1;
    check_all_zero("reset");
    @(negedge clk12);
    #2 reset_n = 1'b1;
    step(pat(0), 1'b0);
    chk("lk_e1_locked", {31'd0, locked}, 0);
    chk("lk_e1_idx", {30'd0, phase_idx}, 0);
    step(pat(1), 1'b0);
    chk("lk_e2_idx", {30'd0, phase_idx}, 1);
    step(pat(2), 1'b0);
    chk("lk_e3_locked", {31'd0, locked}, 0);
    step(pat(3), 1'b0);
    chk("lk_e4_locked", {31'd0, locked}, 1);
    chk("lk_e4_frame", {31'd0, frame}, 0);
    step(pat(0), 1'b0);
    chk("lk_e5_frame", {31'd0, frame}, 1);
    chk("lk_e5_fcnt", {16'd0, frame_count}, 1);
    chk("lk_e5_ecnt", {16'd0, err_count}, 0);
    chk("lk_e5_sticky", {31'd0, err_sticky}, 0);

    // Steady run
    for (int i = 1; i <= 400; i++) begin
      step(pat(i), 1'b0);
      chk($sformatf("run_frame_%0d", i), {31'd0, frame}, (i % 4 == 0) ? 1 : 0);
      chk($sformatf("run_idx_%0d", i), {30'd0, phase_idx}, i % 4);
    end
    chk("run_fcnt", {16'd0, frame_count}, 101);
    chk("run_locked", {31'd0, locked}, 1);
    chk("run_epulse", {31'd0, err_pulse}, 0);

    // Glitch: phi2 and phi3 both low
    step(pat(1), 1'b0);
    step(4'b1001, 1'b0);
    chk("gl_epulse", {31'd0, err_pulse}, 1);
    chk("gl_locked", {31'd0, locked}, 0);
    chk("gl_sticky", {31'd0, err_sticky}, 1);
    chk("gl_ecnt", {16'd0, err_count}, 1);
    chk("gl_idx_hold", {30'd0, phase_idx}, 1);
    step(pat(2), 1'b0);
    chk("gl_epulse_off", {31'd0, err_pulse}, 0);
    step(pat(3), 1'b0);
    step(pat(0), 1'b0);
    chk("gl_relock_e3", {31'd0, locked}, 0);
    chk("gl_no_frame_locking", {31'd0, frame}, 0);
    step(pat(1), 1'b0);
    chk("gl_relock_e4", {31'd0, locked}, 1);
    chk("gl_fcnt", {16'd0, frame_count}, 101);

    // Skip: 2,3,0,1 then 3
    step(pat(2), 1'b0);
    step(pat(3), 1'b0);
    step(pat(0), 1'b0);
    chk("sk_fcnt", {16'd0, frame_count}, 102);
    step(pat(1), 1'b0);
    step(pat(3), 1'b0);
    chk("sk_epulse", {31'd0, err_pulse}, 1);
    chk("sk_locked", {31'd0, locked}, 0);
    chk("sk_ecnt", {16'd0, err_count}, 2);
    chk("sk_idx", {30'd0, phase_idx}, 3);
    for (int i = 0; i < 10; i++) begin
      step(4'b1111, 1'b0);
      chk($sformatf("stuck_epulse_%0d", i), {31'd0, err_pulse}, 0);
      chk($sformatf("stuck_locked_%0d", i), {31'd0, locked}, 0);
    end
    chk("stuck_ecnt", {16'd0, err_count}, 2);
    chk("stuck_idx", {30'd0, phase_idx}, 3);

    // Saturation and clear
    @(negedge clk12);
    reset_n = 1'b0;
    @(posedge clk12);
    #2 reset_n = 1'b1;
    lock_then_fault(1, 1'b0, 1, 1);
    lock_then_fault(2, 1'b0, 2, 2);
    lock_then_fault(3, 1'b0, 3, 3);
    lock_then_fault(4, 1'b0, 4, 3);
    lock_then_fault(5, 1'b0, 5, 3);
    lock_then_fault(6, 1'b1, 1, 1);
    chk("sat_fcnt", {16'd0, frame_count}, 0);
    step(4'b1111, 1'b1);
    chk("clr_ecnt", {16'd0, err_count}, 0);
    chk("clr_s_ecnt", {30'd0, s_err_count}, 0);
    chk("clr_sticky", {31'd0, err_sticky}, 0);
    chk("clr_s_sticky", {31'd0, s_err_sticky}, 0);
    chk("clr_epulse", {31'd0, err_pulse}, 0);

    // Async reset mid-run with frame_count = 7
    for (int i = 0; i <= 28; i++) step(pat(i), 1'b0);
    chk("ar_fcnt", {16'd0, frame_count}, 7);
    chk("ar_frame", {31'd0, frame}, 1);
    chk("ar_locked", {31'd0, locked}, 1);
    @(negedge clk12);
    #2 reset_n = 1'b0;
    #1;
    check_all_zero("areset");
    #1 reset_n = 1'b1;
    step(pat(0), 1'b0);
    step(pat(1), 1'b0);
    step(pat(2), 1'b0);
    chk("ar_relock_e3", {31'd0, locked}, 0);
    step(pat(3), 1'b0);
    chk("ar_relock_e4", {31'd0, locked}, 1);
    step(pat(0), 1'b0);
    chk("ar_relock_frame", {31'd0, frame}, 1);
    chk("ar_relock_fcnt", {16'd0, frame_count}, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
